axi4_mem_slave: RTL

- AXI4 full-protocol memory responder that sits on the far end of the DMA engine's AXI4 master port.
- Serves the DMA's read bursts (source) and write bursts (destination) from one internal word array.
- Used as the target memory in block- and system-level DMA benches, and as a small on-chip scratch RAM.
- Write and read channels run independently, with one outstanding transaction per direction.

---
 rtl/axi4_pkg.sv | 34 +++
 rtl/axi4_mem_slave_if.sv | 74 +++++++
 rtl/axi4_mem_slave_ram.sv | 32 +++
 rtl/axi4_mem_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and FSM state types
// for the memory responder slice.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rstate_t;

  // Only 4-byte beats with FIXED or INCR are served; WRAP and reserved fail
  function automatic logic bad_xfer(
    input logic [2:0] size,
    input logic [1:0] burst
  );
    return (size != 3'd2) ||
           (burst == BURST_WRAP) ||
           (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi4_mem_slave_if.sv
// AXI4 five-channel bundle (no lock/cache/prot/qos/user)
// with master and slave views.
interface axi4_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8
);

  logic [ID_W-1:0]   s_awid;
  logic [ADDR_W-1:0] s_awaddr;
  logic [7:0]        s_awlen;
  logic [2:0]        s_awsize;
  logic [1:0]        s_awburst;
  logic              s_awvalid;
  logic              s_awready;

  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wlast;
  logic              s_wvalid;
  logic              s_wready;

  logic [ID_W-1:0]   s_bid;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;

  logic [ID_W-1:0]   s_arid;
  logic [ADDR_W-1:0] s_araddr;
  logic [7:0]        s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic              s_arvalid;
  logic              s_arready;

  logic [ID_W-1:0]   s_rid;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              s_rvalid;
  logic              s_rready;

  modport slave (
    input  s_awid, s_awaddr, s_awlen,
    input  s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_arid, s_araddr, s_arlen,
    input  s_arsize, s_arburst, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp,
    output s_rlast, s_rvalid,
    input  s_rready
  );

  modport master (
    output s_awid, s_awaddr, s_awlen,
    output s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_arid, s_araddr, s_arlen,
    output s_arsize, s_arburst, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp,
    input  s_rlast, s_rvalid,
    output s_rready
  );

endinterface

// File: rtl/axi4_mem_slave_ram.sv
// 1W/1R byte-enable word array with registered read port;
// a read and write to one word in a cycle returns old data.
module axi4_mem_slave_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [3:0]    be,
  input  logic [31:0]   wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[wa][8*b +: 8] <= wd[8*b +: 8];
        end
      end
    end
    if (re) begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 memory responder: independent write and read FSMs,
// one outstanding burst per direction.
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ID_W         = 8,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  axi4_mem_slave_if.slave s
);

  localparam int WI = ADDR_W - 2;
  localparam int AW = $clog2(DEPTH);
  localparam logic [WI-1:0] DEPTH_W = WI'(DEPTH);
  localparam logic [3:0] WAIT_LAST =
    (READ_LATENCY == 0) ? 4'd0 : 4'(READ_LATENCY - 1);

  // Holds readies low until the first edge after reset release
  logic live;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  wstate_t         wstate, wstate_nx;
  logic [ID_W-1:0] w_id;
  logic [WI-1:0]   w_idx;
  logic [7:0]      w_len, w_cnt;
  logic            w_bad, w_fixed, w_err;
  logic            aw_rdy, w_rdy, b_vld;
  logic            aw_hs, w_hs, w_end;
  logic            w_beat_err, w_lerr;

  assign aw_hs      = s.s_awvalid && aw_rdy;
  assign w_hs       = s.s_wvalid && w_rdy;
  assign w_end      = (w_cnt == w_len);
  assign w_beat_err = w_bad || (w_idx >= DEPTH_W);
  assign w_lerr     = (s.s_wlast != w_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wstate <= W_IDLE;
    else      wstate <= wstate_nx;
  end

  always_comb begin
    wstate_nx = wstate;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    b_vld     = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        aw_rdy = live;
        if (s.s_awvalid && live) wstate_nx = W_DATA;
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (s.s_wvalid && w_end) wstate_nx = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (s.s_bready) wstate_nx = W_IDLE;
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_bad   <= 1'b0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s.s_awid;
      w_idx   <= s.s_awaddr[ADDR_W-1:2];
      w_len   <= s.s_awlen;
      w_cnt   <= '0;
      w_bad   <= bad_xfer(s.s_awsize, s.s_awburst);
      w_fixed <= (s.s_awburst == BURST_FIXED);
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (!w_fixed) w_idx <= w_idx + 1'b1;
      w_err <= w_err | w_beat_err | w_lerr;
    end
  end

  assign s.s_awready = aw_rdy;
  assign s.s_wready  = w_rdy;
  assign s.s_bvalid  = b_vld;
  assign s.s_bid     = w_id;
  assign s.s_bresp   = (b_vld && w_err) ? RESP_SLVERR
                                        : RESP_OKAY;

  rstate_t         rstate, rstate_nx;
  logic [ID_W-1:0] r_id;
  logic [WI-1:0]   r_idx, ld_idx;
  logic [7:0]      r_len, r_cnt;
  logic [3:0]      r_wait;
  logic            r_bad, r_fixed, r_err;
  logic            ar_rdy, r_vld, r_end;
  logic            ar_hs, r_hs, load;
  logic            ld_bad, ld_err;
  logic [DATA_W-1:0] ram_rd;

  assign ar_hs  = s.s_arvalid && ar_rdy;
  assign r_hs   = r_vld && s.s_rready;
  assign r_end  = (r_cnt == r_len);
  assign ld_err = ld_bad || (ld_idx >= DEPTH_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rstate <= R_IDLE;
    else      rstate <= rstate_nx;
  end

  // load marks the edge that fetches the beat about to be presented
  always_comb begin
    rstate_nx = rstate;
    ar_rdy    = 1'b0;
    r_vld     = 1'b0;
    load      = 1'b0;
    ld_idx    = r_idx;
    ld_bad    = r_bad;
    unique case (rstate)
      R_IDLE: begin
        ar_rdy = live;
        ld_idx = s.s_araddr[ADDR_W-1:2];
        ld_bad = bad_xfer(s.s_arsize, s.s_arburst);
        if (s.s_arvalid && live) begin
          if (READ_LATENCY == 0) begin
            rstate_nx = R_DATA;
            load      = 1'b1;
          end else begin
            rstate_nx = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_wait == WAIT_LAST) begin
          rstate_nx = R_DATA;
          load      = 1'b1;
        end
      end
      R_DATA: begin
        r_vld  = 1'b1;
        ld_idx = r_fixed ? r_idx : r_idx + 1'b1;
        if (s.s_rready) begin
          if (r_end) rstate_nx = R_IDLE;
          else       load      = 1'b1;
        end
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_bad   <= 1'b0;
      r_fixed <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id    <= s.s_arid;
        r_idx   <= ld_idx;
        r_len   <= s.s_arlen;
        r_cnt   <= '0;
        r_wait  <= '0;
        r_bad   <= ld_bad;
        r_fixed <= (s.s_arburst == BURST_FIXED);
      end else if (rstate == R_WAIT) begin
        r_wait <= r_wait + 4'd1;
      end
      if (load) r_err <= ld_err;
      if (r_hs && !r_end) begin
        r_cnt <= r_cnt + 8'd1;
        r_idx <= ld_idx;
      end
    end
  end

  axi4_mem_slave_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk (clk),
    .we  (w_hs && !w_beat_err),
    .wa  (w_idx[AW-1:0]),
    .be  (s.s_wstrb),
    .wd  (s.s_wdata),
    .re  (load),
    .ra  (ld_idx[AW-1:0]),
    .rd  (ram_rd)
  );

  assign s.s_arready = ar_rdy;
  assign s.s_rvalid  = r_vld;
  assign s.s_rid     = r_id;
  assign s.s_rlast   = r_vld && r_end;
  assign s.s_rdata   = (r_vld && !r_err) ? ram_rd : '0;
  assign s.s_rresp   = (r_vld && r_err) ? RESP_SLVERR
                                        : RESP_OKAY;

  logic unused_bits;
  assign unused_bits = ^{s.s_awaddr[1:0],
                         s.s_araddr[1:0],
                         w_idx[WI-1:AW],
                         ld_idx[WI-1:AW]};

endmodule
